mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 CLK  in  1  single rising-edge clock for the block.
REQ-002 RST  in  1  asynchronous, active-high reset.
REQ-003 ex_valid  in  1  upstream execute stage presents an instruction.
REQ-004 ex_ready  out  1  stage can accept; high only in IDLE.
REQ-005 ex_result  in  32  ALU output; memory address or writeback value.
REQ-006 ex_v  in  1  ALU signed-overflow flag for this instruction.
REQ-007 ex_trap_ov  in  1  instruction traps on overflow (add/sub, not addu/subu).
REQ-008 ex_store  in  32  store data (rt value).
REQ-009 ex_memread, ex_memwrite, ex_regwrite  in  1 each  control bits; memread and memwrite are never both high.
REQ-010 ex_rd  in  5  destination register index.
REQ-011 flush  in  1  squash the instruction being accepted or in flight.
REQ-012 dREN, dWEN  out  1 each  data-memory read and write request.
REQ-013 daddr  out  32  word-aligned data address.
REQ-014 dstore  out  32  data to write.
REQ-015 dload  in  32  read data, valid when dhit is high.
REQ-016 dhit  in  1  memory completes the current request this cycle.
REQ-017 wb_valid  out  1  one-cycle pulse; a writeback record is present.
REQ-018 wb_regwrite  out  1  the record writes the register file.
REQ-019 wb_rd  out  5  destination register index for the record.
REQ-020 wb_data  out  32  writeback value for the record.
REQ-021 exc_ov, exc_adel, exc_ades  out  1 each  one-cycle exception pulses, aligned with wb_valid.

Function
REQ-022 FSM states: IDLE and WAIT.
REQ-023 Accept occurs at a clock edge when ex_valid and ex_ready are both high; the instruction fields are latched into the stage register.
REQ-024 Non-memory accept: state stays IDLE; the next cycle gives wb_valid=1, wb_data=ex_result, wb_regwrite=ex_regwrite.
REQ-025 Memory accept with aligned address (ex_result[1:0]==0): state goes to WAIT; ex_ready=0 while in WAIT.
REQ-026 In WAIT, dREN=memread or dWEN=memwrite is driven from the registered fields, with daddr=latched result and dstore=latched store data; both stay steady until dhit.
REQ-027 On the edge where dhit=1 in WAIT: dload is captured for loads; state returns to IDLE; the next cycle gives wb_valid=1.
REQ-028 Load record: wb_data=captured dload and wb_regwrite=1. Store record: wb_regwrite=0.
REQ-029 Overflow trap (ex_v and ex_trap_ov at accept): no memory access; next cycle gives wb_valid=1, wb_regwrite=0, exc_ov=1.
REQ-030 Misaligned memory op: no request; next cycle gives wb_valid=1, wb_regwrite=0, plus exc_adel for a load or exc_ades for a store.
REQ-031 Overflow takes priority over misalignment when both apply.
REQ-032 flush with an accept: the instruction is dropped; no wb_valid and no exception pulse.
REQ-033 flush in WAIT: the request is not withdrawn and runs to dhit; the resulting record has wb_regwrite=0 and no exception.
REQ-034 dhit outside WAIT is ignored.
REQ-035 In WAIT, dREN and dWEN are never both asserted.
REQ-036 Back-to-back non-memory accepts give one wb_valid pulse per cycle.
REQ-037 Minimum latency: 1 cycle for non-memory ops; memory ops take 1 + (cycles to dhit).

Reset
REQ-038 RST asynchronously forces: state=IDLE; dREN, dWEN, wb_valid, wb_regwrite and all exc_* to 0; daddr, dstore, wb_data to 0; wb_rd to 0.
REQ-039 RST asserted mid-WAIT drops the request in the same cycle; no record is produced after reset releases.
REQ-040 After reset release, ex_ready=1 in the first cycle.

Structure
REQ-041 word_t, regbits_t and the mem_state_t enum (IDLE, WAIT) live in cpu_types_pkg.
REQ-042 Exception cause encodings live in cpu_types_pkg.
REQ-043 One sub-module, mem_stage_reg, holds the latched instruction fields with load-enable and clear.

Verification
REQ-044 Accept add, ex_result=32'h0000_0010, rd=5, regwrite=1 -> next cycle wb_valid=1, wb_data=32'h10, wb_rd=5, no dREN.
REQ-045 Accept load at 32'h0000_0100; hold dhit=0 for 3 cycles, then dhit=1 with dload=32'hDEAD_BEEF -> dREN high 4 cycles, daddr=32'h100, wb_data=32'hDEAD_BEEF one cycle after dhit, ex_ready=0 throughout.
REQ-046 Accept store at 32'h0000_0102 -> no dWEN, exc_ades=1, wb_regwrite=0; then a load with ex_v=1, ex_trap_ov=1 -> exc_ov=1, no dREN.
REQ-047 Accept store at 32'h200 with data 32'hCAFE_F00D, flush in the first WAIT cycle, dhit after 2 cycles -> dWEN held until dhit, record has wb_regwrite=0 and no exception.
REQ-048 Assert RST during WAIT -> dREN=0 in the same cycle, no wb_valid afterward, ex_ready=1 after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register aliases, memory-stage state,
// exception causes and the latched memory-stage instruction record.
package cpu_types_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned REG_W  = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   // MIPS cause codes
   typedef enum logic [4:0] {
      EXC_NONE = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_OV   = 5'd12
   } exc_cause_t;

   typedef struct packed {
      word_t    result;
      word_t    store;
      regbits_t rd;
      logic     memread;
      logic     memwrite;
      logic     squashed;
   } mem_fields_t;

   // Overflow outranks misalignment; only memory ops can be misaligned
   function automatic exc_cause_t classify(input logic v, input logic trap_ov,
                                           input logic memread, input logic memwrite,
                                           input logic [1:0] lsb);
      if (v && trap_ov)               return EXC_OV;
      if (memread && (lsb != 2'b00))  return EXC_ADEL;
      if (memwrite && (lsb != 2'b00)) return EXC_ADES;
      return EXC_NONE;
   endfunction

endpackage

// File: rtl/mem_stage_reg.sv
// Stage register holding the fields of the memory op in flight.
module mem_stage_reg
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        load,
   input  logic        clr,
   input  mem_fields_t d,
   output mem_fields_t q
);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)       q <= '0;
      else if (clr)  q <= '0;
      else if (load) q <= d;
   end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: forwards ALU results, runs data-memory requests,
// and raises overflow / address-error exceptions as one-cycle records.
module mem_stage
   import cpu_types_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [WORD_W-1:0] ex_result,
   input  logic              ex_v,
   input  logic              ex_trap_ov,
   input  logic [WORD_W-1:0] ex_store,
   input  logic              ex_memread,
   input  logic              ex_memwrite,
   input  logic              ex_regwrite,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              flush,
   output logic              dREN,
   output logic              dWEN,
   output logic [WORD_W-1:0] daddr,
   output logic [WORD_W-1:0] dstore,
   input  logic [WORD_W-1:0] dload,
   input  logic              dhit,
   output logic              wb_valid,
   output logic              wb_regwrite,
   output logic [REG_W-1:0]  wb_rd,
   output logic [WORD_W-1:0] wb_data,
   output logic              exc_ov,
   output logic              exc_adel,
   output logic              exc_ades
);

   mem_state_t  state, state_d;
   mem_fields_t fields_q, fields_d;
   exc_cause_t  cause;
   logic        accept, is_mem, go_wait, reg_load, reg_clr;

   logic              dren_d, dwen_d, wb_valid_d, wb_regwrite_d;
   logic              exc_ov_d, exc_adel_d, exc_ades_d;
   logic [WORD_W-1:0] daddr_d, dstore_d, wb_data_d;
   logic [REG_W-1:0]  wb_rd_d;

   assign ex_ready = (state == IDLE);
   assign accept   = ex_valid & ex_ready;
   assign is_mem   = ex_memread | ex_memwrite;
   assign cause    = classify(ex_v, ex_trap_ov, ex_memread, ex_memwrite, ex_result[1:0]);
   assign go_wait  = accept & ~flush & is_mem & (cause == EXC_NONE);
   assign reg_load = go_wait | ((state == WAIT) & flush);
   assign reg_clr  = (state == WAIT) & dhit;

   // Accept latches fresh fields; a flush in WAIT only marks the op squashed
   always_comb begin
      fields_d          = fields_q;
      fields_d.squashed = 1'b1;
      if (state == IDLE) begin
         fields_d.result   = ex_result;
         fields_d.store    = ex_store;
         fields_d.rd       = ex_rd;
         fields_d.memread  = ex_memread;
         fields_d.memwrite = ex_memwrite;
         fields_d.squashed = 1'b0;
      end
   end

   mem_stage_reg u_reg (
      .CLK  (CLK),
      .RST  (RST),
      .load (reg_load),
      .clr  (reg_clr),
      .d    (fields_d),
      .q    (fields_q)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (go_wait) state_d = WAIT;
         WAIT:    if (dhit)    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      dren_d        = dREN;
      dwen_d        = dWEN;
      daddr_d       = daddr;
      dstore_d      = dstore;
      wb_valid_d    = 1'b0;
      wb_regwrite_d = 1'b0;
      wb_rd_d       = wb_rd;
      wb_data_d     = wb_data;
      exc_ov_d      = 1'b0;
      exc_adel_d    = 1'b0;
      exc_ades_d    = 1'b0;
      case (state)
         IDLE: begin
            if (go_wait) begin
               dren_d   = ex_memread;
               dwen_d   = ex_memwrite;
               daddr_d  = ex_result;
               dstore_d = ex_store;
            end else if (accept && !flush) begin
               wb_valid_d    = 1'b1;
               wb_rd_d       = ex_rd;
               wb_data_d     = ex_result;
               wb_regwrite_d = (cause == EXC_NONE) & ex_regwrite;
               exc_ov_d      = (cause == EXC_OV);
               exc_adel_d    = (cause == EXC_ADEL);
               exc_ades_d    = (cause == EXC_ADES);
            end
         end
         WAIT: begin
            dren_d   = fields_q.memread & ~dhit;
            dwen_d   = fields_q.memwrite & ~dhit;
            daddr_d  = fields_q.result;
            dstore_d = fields_q.store;
            if (dhit) begin
               wb_valid_d    = 1'b1;
               wb_rd_d       = fields_q.rd;
               wb_data_d     = fields_q.memread ? dload : fields_q.result;
               wb_regwrite_d = fields_q.memread & ~(fields_q.squashed | flush);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dREN        <= 1'b0;
         dWEN        <= 1'b0;
         daddr       <= '0;
         dstore      <= '0;
         wb_valid    <= 1'b0;
         wb_regwrite <= 1'b0;
         wb_rd       <= '0;
         wb_data     <= '0;
         exc_ov      <= 1'b0;
         exc_adel    <= 1'b0;
         exc_ades    <= 1'b0;
      end else begin
         dREN        <= dren_d;
         dWEN        <= dwen_d;
         daddr       <= daddr_d;
         dstore      <= dstore_d;
         wb_valid    <= wb_valid_d;
         wb_regwrite <= wb_regwrite_d;
         wb_rd       <= wb_rd_d;
         wb_data     <= wb_data_d;
         exc_ov      <= exc_ov_d;
         exc_adel    <= exc_adel_d;
         exc_ades    <= exc_ades_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed multi-cycle
// sequences, and a randomized run against a transaction-level model.
module tb_mem_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ex_valid, ex_ready, ex_v, ex_trap_ov, ex_memread, ex_memwrite, ex_regwrite, flush;
   logic [31:0] ex_result, ex_store, daddr, dstore, dload, wb_data;
   logic [4:0]  ex_rd, wb_rd;
   logic        dREN, dWEN, dhit, wb_valid, wb_regwrite, exc_ov, exc_adel, exc_ades;

   int checks   = 0;
   int failures = 0;

   mem_stage dut (
      .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_result(ex_result), .ex_v(ex_v), .ex_trap_ov(ex_trap_ov), .ex_store(ex_store),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
      .ex_rd(ex_rd), .flush(flush), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
      .dstore(dstore), .dload(dload), .dhit(dhit), .wb_valid(wb_valid),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .exc_ov(exc_ov), .exc_adel(exc_adel), .exc_ades(exc_ades)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        valid, v, trap, mr, mw, rw, fl;
      logic [31:0] result;
      logic [4:0]  rd;
      logic        e_wbv, e_rw, e_ov, e_adel, e_ades, e_dren, e_dwen;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   // Advance one active edge; outputs are then sampled at the falling edge
   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic idle_inputs();
      ex_valid = 0; ex_v = 0; ex_trap_ov = 0; ex_memread = 0; ex_memwrite = 0;
      ex_regwrite = 0; flush = 0; dhit = 0; ex_result = '0; ex_store = '0;
      ex_rd = '0; dload = '0;
   endtask

   task automatic drive(input logic valid, input logic [31:0] result, input logic mr,
                        input logic mw, input logic rw, input logic [4:0] rd);
      ex_valid = valid; ex_result = result; ex_memread = mr; ex_memwrite = mw;
      ex_regwrite = rw; ex_rd = rd;
   endtask

   function automatic vec_t mk(input logic valid, input logic [31:0] result, input logic v,
                               input logic trap, input logic mr, input logic mw, input logic rw,
                               input logic fl, input logic [4:0] rd, input logic e_wbv,
                               input logic e_rw, input logic e_ov, input logic e_adel,
                               input logic e_ades, input logic e_dren, input logic e_dwen);
      vec_t r;
      r.valid = valid; r.result = result; r.v = v; r.trap = trap; r.mr = mr; r.mw = mw;
      r.rw = rw; r.fl = fl; r.rd = rd; r.e_wbv = e_wbv; r.e_rw = e_rw; r.e_ov = e_ov;
      r.e_adel = e_adel; r.e_ades = e_ades; r.e_dren = e_dren; r.e_dwen = e_dwen;
      return r;
   endfunction

   // Random-run model state: the memory op in flight, if any
   logic        m_busy, m_rd_op, m_wr_op, m_sq;
   logic [31:0] m_addr, m_st;
   logic [4:0]  m_rd;
   logic        e_v, e_rw, e_ov, e_adel, e_ades, e_dchk, e_rdchk;
   logic [31:0] e_data;
   logic [4:0]  e_rd;
   int          kind, dren_cycles;

   initial begin
      //                valid result        v  tr mr mw rw fl rd   wbv rw ov adl ads drn dwn
      vecs[0]  = mk(1, 32'h0000_0010, 0, 0, 0, 0, 1, 0, 5,  1, 1, 0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 32'hFFFF_FFF0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(1, 32'h7FFF_FFFF, 1, 1, 0, 0, 1, 0, 7,  1, 0, 1, 0, 0, 0, 0);
      vecs[3]  = mk(1, 32'h8000_0000, 1, 0, 0, 0, 1, 0, 9,  1, 1, 0, 0, 0, 0, 0);
      vecs[4]  = mk(1, 32'h0000_0102, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0);
      vecs[5]  = mk(1, 32'h0000_0203, 0, 0, 1, 0, 1, 0, 3,  1, 0, 0, 1, 0, 0, 0);
      vecs[6]  = mk(1, 32'h0000_0001, 1, 1, 1, 0, 1, 0, 4,  1, 0, 1, 0, 0, 0, 0);
      vecs[7]  = mk(1, 32'h0000_0100, 1, 1, 1, 0, 1, 0, 6,  1, 0, 1, 0, 0, 0, 0);
      vecs[8]  = mk(1, 32'h0000_0044, 0, 0, 0, 0, 1, 1, 2,  0, 0, 0, 0, 0, 0, 0);
      vecs[9]  = mk(1, 32'h0000_0106, 0, 0, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
      vecs[10] = mk(1, 32'h0000_0300, 0, 0, 1, 0, 1, 0, 8,  0, 0, 0, 0, 0, 1, 0);
      vecs[11] = mk(1, 32'h0000_0304, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
      vecs[12] = mk(0, 32'h0000_0055, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0);

      // Reset values, sampled while reset is held
      idle_inputs();
      RST = 1'b1;
      #12;
      chkb("rst.dREN", dREN, 0);   chkb("rst.dWEN", dWEN, 0);
      chkb("rst.wb_valid", wb_valid, 0); chkb("rst.wb_regwrite", wb_regwrite, 0);
      chkb("rst.exc_ov", exc_ov, 0); chkb("rst.exc_adel", exc_adel, 0);
      chkb("rst.exc_ades", exc_ades, 0);
      chk("rst.daddr", daddr, 0); chk("rst.dstore", dstore, 0);
      chk("rst.wb_data", wb_data, 0); chk("rst.wb_rd", 32'(wb_rd), 0);
      @(negedge CLK);
      RST = 1'b0;
      chkb("rst.ex_ready_first", ex_ready, 1);

      // Single-accept vector table
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].valid, vecs[i].result, vecs[i].mr, vecs[i].mw, vecs[i].rw, vecs[i].rd);
         ex_v = vecs[i].v; ex_trap_ov = vecs[i].trap; flush = vecs[i].fl;
         ex_store = 32'h1234_5678;
         step();
         idle_inputs();
         chkb($sformatf("v%0d.wb_valid", i), wb_valid, vecs[i].e_wbv);
         if (vecs[i].e_wbv) chkb($sformatf("v%0d.wb_regwrite", i), wb_regwrite, vecs[i].e_rw);
         if (vecs[i].e_wbv && !(vecs[i].e_ov || vecs[i].e_adel || vecs[i].e_ades)) begin
            chk($sformatf("v%0d.wb_data", i), wb_data, vecs[i].result);
            chk($sformatf("v%0d.wb_rd", i), 32'(wb_rd), 32'(vecs[i].rd));
         end
         chkb($sformatf("v%0d.exc_ov", i), exc_ov, vecs[i].e_ov);
         chkb($sformatf("v%0d.exc_adel", i), exc_adel, vecs[i].e_adel);
         chkb($sformatf("v%0d.exc_ades", i), exc_ades, vecs[i].e_ades);
         chkb($sformatf("v%0d.dREN", i), dREN, vecs[i].e_dren);
         chkb($sformatf("v%0d.dWEN", i), dWEN, vecs[i].e_dwen);
         chkb($sformatf("v%0d.ex_ready", i), ex_ready, !(vecs[i].e_dren || vecs[i].e_dwen));
         if (vecs[i].e_dren || vecs[i].e_dwen) begin
            chk($sformatf("v%0d.daddr", i), daddr, vecs[i].result);
            if (vecs[i].e_dwen) chk($sformatf("v%0d.dstore", i), dstore, 32'h1234_5678);
            dhit = 1;
            step();
            dhit = 0;
            step();
         end
      end

      // Load with three wait cycles
      drive(1, 32'h0000_0100, 1, 0, 1, 10);
      step();
      idle_inputs();
      dren_cycles = 0;
      for (int c = 0; c < 4; c++) begin
         if (dREN) dren_cycles++;
         chk($sformatf("ld.daddr%0d", c), daddr, 32'h100);
         chkb($sformatf("ld.ex_ready%0d", c), ex_ready, 0);
         chkb($sformatf("ld.wb_valid%0d", c), wb_valid, 0);
         if (c == 3) begin dhit = 1; dload = 32'hDEAD_BEEF; end
         step();
      end
      dhit = 0; dload = '0;
      chk("ld.dren_cycles", 32'(dren_cycles), 4);
      chkb("ld.wb_valid", wb_valid, 1);
      chk("ld.wb_data", wb_data, 32'hDEAD_BEEF);
      chkb("ld.wb_regwrite", wb_regwrite, 1);
      chk("ld.wb_rd", 32'(wb_rd), 10);
      chkb("ld.dREN_after", dREN, 0);
      chkb("ld.ex_ready_after", ex_ready, 1);
      step();
      chkb("ld.wb_valid_pulse", wb_valid, 0);

      // Store flushed in its first WAIT cycle still runs to dhit
      drive(1, 32'h0000_0200, 0, 1, 0, 0);
      ex_store = 32'hCAFE_F00D;
      step();
      idle_inputs();
      chkb("stf.dWEN0", dWEN, 1);
      chk("stf.dstore", dstore, 32'hCAFE_F00D);
      flush = 1;
      step();
      flush = 0;
      chkb("stf.dWEN1", dWEN, 1);
      chk("stf.daddr", daddr, 32'h200);
      dhit = 1;
      step();
      dhit = 0;
      chkb("stf.wb_valid", wb_valid, 1);
      chkb("stf.wb_regwrite", wb_regwrite, 0);
      chkb("stf.exc_any", exc_ov | exc_adel | exc_ades, 0);
      chkb("stf.dWEN_after", dWEN, 0);

      // dhit while idle is ignored
      dhit = 1;
      step();
      step();
      dhit = 0;
      chkb("idlehit.wb_valid", wb_valid, 0);
      chkb("idlehit.dREN", dREN, 0);

      // Reset in the middle of a load wait
      drive(1, 32'h0000_0400, 1, 0, 1, 12);
      step();
      idle_inputs();
      chkb("rstw.dREN_before", dREN, 1);
      #1 RST = 1'b1;
      #1 chkb("rstw.dREN_same_cycle", dREN, 0);
      @(negedge CLK);
      RST = 1'b0;
      chkb("rstw.ex_ready", ex_ready, 1);
      dhit = 1;
      for (int c = 0; c < 3; c++) begin
         step();
         chkb($sformatf("rstw.wb_valid%0d", c), wb_valid, 0);
      end
      dhit = 0;

      // Randomized run against the transaction model
      m_busy = 0; m_rd_op = 0; m_wr_op = 0; m_sq = 0; m_addr = '0; m_st = '0; m_rd = '0;
      for (int n = 0; n < 400; n++) begin
         kind        = int'($urandom_range(0, 2));
         ex_valid    = ($urandom_range(0, 9) < 6);
         ex_result   = $urandom;
         if ($urandom_range(0, 3) != 0) ex_result[1:0] = 2'b00;
         ex_v        = ($urandom_range(0, 4) == 0);
         ex_trap_ov  = 1'($urandom_range(0, 1));
         ex_store    = $urandom;
         ex_rd       = 5'($urandom);
         ex_memread  = (kind == 1);
         ex_memwrite = (kind == 2);
         ex_regwrite = (kind == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         flush       = ($urandom_range(0, 9) == 0);
         dhit        = ($urandom_range(0, 9) < 4);
         dload       = $urandom;

         chkb("rnd.ex_ready", ex_ready, !m_busy);
         chkb("rnd.dREN", dREN, m_busy && m_rd_op);
         chkb("rnd.dWEN", dWEN, m_busy && m_wr_op);
         if (m_busy) chk("rnd.daddr", daddr, m_addr);
         if (m_busy && m_wr_op) chk("rnd.dstore", dstore, m_st);

         e_v = 0; e_rw = 0; e_ov = 0; e_adel = 0; e_ades = 0; e_dchk = 0; e_rdchk = 0;
         e_data = '0; e_rd = '0;
         if (m_busy) begin
            if (flush) m_sq = 1;
            if (dhit) begin
               e_v = 1; e_rw = m_rd_op && !m_sq; e_rd = m_rd; e_rdchk = 1;
               e_data = dload; e_dchk = m_rd_op;
               m_busy = 0;
            end
         end else if (ex_valid && !flush) begin
            if (ex_v && ex_trap_ov) begin
               e_v = 1; e_ov = 1;
            end else if (kind != 0 && ex_result[1:0] != 2'b00) begin
               e_v = 1; e_adel = (kind == 1); e_ades = (kind == 2);
            end else if (kind != 0) begin
               m_busy = 1; m_sq = 0; m_rd_op = (kind == 1); m_wr_op = (kind == 2);
               m_addr = ex_result; m_st = ex_store; m_rd = ex_rd;
            end else begin
               e_v = 1; e_rw = ex_regwrite; e_data = ex_result; e_dchk = 1;
               e_rd = ex_rd; e_rdchk = 1;
            end
         end
         step();
         chkb("rnd.wb_valid", wb_valid, e_v);
         if (e_v) chkb("rnd.wb_regwrite", wb_regwrite, e_rw);
         if (e_dchk) chk("rnd.wb_data", wb_data, e_data);
         if (e_rdchk) chk("rnd.wb_rd", 32'(wb_rd), 32'(e_rd));
         chkb("rnd.exc_ov", exc_ov, e_ov);
         chkb("rnd.exc_adel", exc_adel, e_adel);
         chkb("rnd.exc_ades", exc_ades, e_ades);
      end
      idle_inputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
